// File: rtl/centroid_tracker_if.sv
// Purpose : k-means result bus into the tracker plus the tracker's published tracks/seeds.
// Latency : n/a (signal bundle only).
// Backpr. : none; the producer sees busy_out and dropped_out, and there are no ready signals.
// Ports   : none. The master modport is the k-means/juggling side and the slave modport is the
//           tracker. Inputs: centroids_x_in/centroids_y_in, num_balls, data_valid_in.
//           Outputs: tracks_*, track_valid_out, jump_out, seed_*, data_valid_out, busy_out,
//           dropped_out.
interface centroid_tracker_if;
  logic [6:0][8:0] centroids_x_in;
  logic [6:0][7:0] centroids_y_in;
  logic [2:0]      num_balls;
  logic            data_valid_in;
  logic [6:0][8:0] tracks_x_out;
  logic [6:0][7:0] tracks_y_out;
  logic [6:0]      track_valid_out;
  logic [6:0]      jump_out;
  logic [6:0][8:0] seed_x_out;
  logic [6:0][7:0] seed_y_out;
  logic            data_valid_out;
  logic            busy_out;
  logic            dropped_out;

  modport master (
    output centroids_x_in, centroids_y_in, num_balls, data_valid_in,
    input  tracks_x_out, tracks_y_out, track_valid_out, jump_out,
           seed_x_out, seed_y_out, data_valid_out, busy_out, dropped_out
  );

  modport slave (
    input  centroids_x_in, centroids_y_in, num_balls, data_valid_in,
    output tracks_x_out, tracks_y_out, track_valid_out, jump_out,
           seed_x_out, seed_y_out, data_valid_out, busy_out, dropped_out
  );
endinterface

// File: rtl/centroid_tracker.sv
// Purpose : Greedy nearest-Manhattan matching of the k-means centroids to last frame's tracks, and seeds for the next frame.
// Latency : data_valid_out follows n+1 edges after the sampling edge (matched frame), or 1 edge (identity frame).
// Backpr. : No stall. A data_valid_in that arrives while busy_out is high is discarded and reported on dropped_out.
// Ports   : clk_in, rst_in (async, active-high) and bus (centroid_tracker_if.slave).
// Option  : `define VELOCITY_PREDICT_EN -> seed = clamp(2*track - prev_track). The default is seed = track.
module centroid_tracker #(
  parameter int MAX_BALLS = 7,   // fixed to match the k-means array size
  parameter int MAX_JUMP  = 40,
  parameter int FRAME_W   = 320,
  parameter int FRAME_H   = 180
) (
  input  logic              clk_in,
  input  logic              rst_in,
  centroid_tracker_if.slave bus
);

  typedef enum logic [1:0] {IDLE, MATCH, COMMIT} state_t;

  state_t                    r_state;
  logic [MAX_BALLS-1:0][8:0] r_cand_x;
  logic [MAX_BALLS-1:0][7:0] r_cand_y;
  logic [2:0]                r_n;
  logic [2:0]                r_prev_n;
  logic [2:0]                r_t;
  logic                      r_init;
  logic [MAX_BALLS-1:0]      r_claimed;
  logic [MAX_BALLS-1:0]      r_jump_pend;
  logic [MAX_BALLS-1:0][2:0] r_assign;
  logic [MAX_BALLS-1:0][8:0] r_trk_x;
  logic [MAX_BALLS-1:0][7:0] r_trk_y;
  logic [MAX_BALLS-1:0][8:0] r_seed_x;
  logic [MAX_BALLS-1:0][7:0] r_seed_y;
  logic [MAX_BALLS-1:0]      r_valid;
  logic [MAX_BALLS-1:0]      r_jump;
  logic                      r_dv_out;
  logic                      r_busy;
  logic                      r_dropped;

  logic [MAX_BALLS-1:0][9:0] w_dist;
  logic [2:0]                w_best_idx;
  logic [9:0]                w_best_dist;
  logic                      w_found;
  logic [MAX_BALLS-1:0][8:0] w_new_x;
  logic [MAX_BALLS-1:0][7:0] w_new_y;

  function automatic logic [9:0] manhattan(input logic [8:0] ax, input logic [7:0] ay,
                                           input logic [8:0] bx, input logic [7:0] by);
    logic [8:0] dx;
    logic [7:0] dy;
    dx = (ax > bx) ? (ax - bx) : (bx - ax);
    dy = (ay > by) ? (ay - by) : (by - ay);
    return {1'b0, dx} + {2'b00, dy};
  endfunction

`ifdef VELOCITY_PREDICT_EN
  // The extrapolation uses 11-bit signed arithmetic. 2*511 still fits, so the clamp sees the true value.
  function automatic logic [8:0] predict_x(input logic [8:0] cur, input logic [8:0] prev);
    logic signed [10:0] v;
    v = $signed({1'b0, cur, 1'b0}) - $signed({2'b00, prev});
    if (v < 0)                              return 9'd0;
    else if (v > $signed(11'(FRAME_W - 1))) return 9'(FRAME_W - 1);
    else                                    return v[8:0];
  endfunction

  function automatic logic [7:0] predict_y(input logic [7:0] cur, input logic [7:0] prev);
    logic signed [10:0] v;
    v = $signed({2'b00, cur, 1'b0}) - $signed({3'b000, prev});
    if (v < 0)                              return 8'd0;
    else if (v > $signed(11'(FRAME_H - 1))) return 8'(FRAME_H - 1);
    else                                    return v[7:0];
  endfunction

  // This is set on identity frames. It forces seed = track because there is no motion history.
  logic                      r_ident;
  logic [MAX_BALLS-1:0][8:0] w_pred_x;
  logic [MAX_BALLS-1:0][7:0] w_pred_y;

  // At the commit edge the track register still holds the previous frame's position.
  always_comb begin
    for (int s = 0; s < MAX_BALLS; s++) begin
      w_pred_x[s] = predict_x(w_new_x[s], r_trk_x[s]);
      w_pred_y[s] = predict_y(w_new_y[s], r_trk_y[s]);
    end
  end
`endif

  // Compute the distance from the slot currently being matched to every latched candidate.
  always_comb begin
    for (int i = 0; i < MAX_BALLS; i++)
      w_dist[i] = manhattan(r_trk_x[r_t], r_trk_y[r_t], r_cand_x[i], r_cand_y[i]);
  end

  // Select the minimum over unclaimed candidates below n. The strict '<' gives ties to the lowest index.
  always_comb begin
    w_best_idx  = '0;
    w_best_dist = '0;
    w_found     = 1'b0;
    for (int i = 0; i < MAX_BALLS; i++) begin
      if ((3'(i) < r_n) && !r_claimed[i] && (!w_found || (w_dist[i] < w_best_dist))) begin
        w_found     = 1'b1;
        w_best_idx  = 3'(i);
        w_best_dist = w_dist[i];
      end
    end
  end

  always_comb begin
    for (int s = 0; s < MAX_BALLS; s++) begin
      w_new_x[s] = r_cand_x[r_assign[s]];
      w_new_y[s] = r_cand_y[r_assign[s]];
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_state     <= IDLE;
      r_cand_x    <= '0;
      r_cand_y    <= '0;
      r_n         <= '0;
      r_prev_n    <= '0;
      r_t         <= '0;
      r_init      <= 1'b0;
      r_claimed   <= '0;
      r_jump_pend <= '0;
      r_assign    <= '0;
      r_trk_x     <= '0;
      r_trk_y     <= '0;
      r_valid     <= '0;
      r_jump      <= '0;
      r_dv_out    <= 1'b0;
      r_busy      <= 1'b0;
      r_dropped   <= 1'b0;
      for (int i = 0; i < MAX_BALLS; i++) begin
        r_seed_x[i] <= 9'((i + 1) * 40);
        r_seed_y[i] <= 8'd90;
      end
`ifdef VELOCITY_PREDICT_EN
      r_ident     <= 1'b0;
`endif
    end else begin
      r_dv_out  <= 1'b0;
      // busy_out is still high on the commit edge, so a pulse arriving on that edge is dropped as well.
      r_dropped <= bus.data_valid_in && r_busy;

      case (r_state)
        IDLE: begin
          if (bus.data_valid_in) begin
            r_cand_x    <= bus.centroids_x_in;
            r_cand_y    <= bus.centroids_y_in;
            r_n         <= bus.num_balls;
            r_claimed   <= '0;
            r_jump_pend <= '0;
            r_t         <= '0;
            r_busy      <= 1'b1;
            for (int s = 0; s < MAX_BALLS; s++) r_assign[s] <= 3'(s);
            if ((bus.num_balls != 3'd0) && r_init && (bus.num_balls == r_prev_n)) begin
              r_state <= MATCH;
`ifdef VELOCITY_PREDICT_EN
              r_ident <= 1'b0;
`endif
            end else begin
              r_state <= COMMIT;
`ifdef VELOCITY_PREDICT_EN
              r_ident <= 1'b1;
`endif
            end
          end
        end

        MATCH: begin
          r_claimed[w_best_idx] <= 1'b1;
          r_assign[r_t]         <= w_best_idx;
          r_jump_pend[r_t]      <= (w_best_dist > 10'(MAX_JUMP));
          if (r_t == r_n - 3'd1) r_state <= COMMIT;
          else                   r_t     <= r_t + 3'd1;
        end

        COMMIT: begin
          for (int s = 0; s < MAX_BALLS; s++) begin
            if (3'(s) < r_n) begin
              r_trk_x[s] <= w_new_x[s];
              r_trk_y[s] <= w_new_y[s];
              r_valid[s] <= 1'b1;
              r_jump[s]  <= r_jump_pend[s];
`ifdef VELOCITY_PREDICT_EN
              r_seed_x[s] <= r_ident ? w_new_x[s] : w_pred_x[s];
              r_seed_y[s] <= r_ident ? w_new_y[s] : w_pred_y[s];
`else
              r_seed_x[s] <= w_new_x[s];
              r_seed_y[s] <= w_new_y[s];
`endif
            end else begin
              // Inactive slots keep their positions and seeds, so a returning ball has a sensible start point.
              r_valid[s] <= 1'b0;
              r_jump[s]  <= 1'b0;
            end
          end
          r_init   <= 1'b1;
          r_prev_n <= r_n;
          r_dv_out <= 1'b1;
          r_busy   <= 1'b0;
          r_state  <= IDLE;
        end

        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.tracks_x_out    = r_trk_x;
  assign bus.tracks_y_out    = r_trk_y;
  assign bus.track_valid_out = r_valid;
  assign bus.jump_out        = r_jump;
  assign bus.seed_x_out      = r_seed_x;
  assign bus.seed_y_out      = r_seed_y;
  assign bus.data_valid_out  = r_dv_out;
  assign bus.busy_out        = r_busy;
  assign bus.dropped_out     = r_dropped;

endmodule

// File: tb/tb_centroid_tracker.sv
// Purpose : Randomized scoreboard bench for centroid_tracker against a frame-level reference model.
// Latency : each expected frame carries the cycle in which data_valid_out must appear.
// Backpr. : injects pulses while busy and expects dropped_out with unchanged results.
module tb_centroid_tracker;
  localparam int MAXJ = 40;
  localparam int FW   = 320;
  localparam int FH   = 180;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  centroid_tracker_if bus();
  centroid_tracker dut (.clk_in(clk), .rst_in(rst), .bus(bus));

  typedef struct {
    int              cyc;
    logic [6:0][8:0] tx;
    logic [6:0][7:0] ty;
    logic [6:0]      v;
    logic [6:0]      j;
    logic [6:0][8:0] sx;
    logic [6:0][7:0] sy;
  } exp_t;

  exp_t exp_q[$];
  int   drop_q[$];
  exp_t held, mdl, mon_e;
  bit   m_init;
  int   m_prevn;
  int   cyc = 0, tests = 0, fails = 0, done_cnt = 0;
  int   last_s, last_lat;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  function automatic int clampi(input int v, input int lo, input int hi);
    return (v < lo) ? lo : ((v > hi) ? hi : v);
  endfunction

  function automatic logic [255:0] pack(input exp_t e);
    return {4'b0, e.tx, e.ty, e.v, e.j, e.sx, e.sy};
  endfunction

  function automatic logic [255:0] dut_pack();
    return {4'b0, bus.tracks_x_out, bus.tracks_y_out, bus.track_valid_out, bus.jump_out,
            bus.seed_x_out, bus.seed_y_out};
  endfunction

  task automatic chk(input string nm, input logic [255:0] a, input logic [255:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, a, e);
    end
  endtask

  task automatic reset_model();
    for (int i = 0; i < 7; i++) begin
      mdl.tx[i] = '0; mdl.ty[i] = '0;
      mdl.sx[i] = 9'((i + 1) * 40); mdl.sy[i] = 8'd90;
    end
    mdl.v = '0; mdl.j = '0; mdl.cyc = 0;
    m_init = 0; m_prevn = 0;
  endtask

  // Frame-level model: the greedy slot-by-slot nearest match, written directly with integer arithmetic.
  task automatic model_frame(input logic [6:0][8:0] cx, input logic [6:0][7:0] cy,
                             input int n, output int lat);
    bit claimed[7];
    int asg[7];
    bit jmp[7];
    bit match;
    int best, bd, d, nx, ny;
    logic [6:0][8:0] ox;
    logic [6:0][7:0] oy;
    ox = mdl.tx; oy = mdl.ty;
    match = (n > 0) && m_init && (n == m_prevn);
    for (int i = 0; i < 7; i++) begin claimed[i] = 0; asg[i] = i; jmp[i] = 0; end
    if (match) begin
      for (int t = 0; t < n; t++) begin
        best = -1; bd = 0;
        for (int i = 0; i < n; i++) begin
          if (!claimed[i]) begin
            d = iabs(int'(ox[t]) - int'(cx[i])) + iabs(int'(oy[t]) - int'(cy[i]));
            if (best < 0 || d < bd) begin best = i; bd = d; end
          end
        end
        claimed[best] = 1; asg[t] = best; jmp[t] = (bd > MAXJ);
      end
    end
    for (int s = 0; s < 7; s++) begin
      if (s < n) begin
        nx = int'(cx[asg[s]]); ny = int'(cy[asg[s]]);
        mdl.tx[s] = 9'(nx); mdl.ty[s] = 8'(ny);
        mdl.v[s] = 1'b1; mdl.j[s] = jmp[s];
`ifdef VELOCITY_PREDICT_EN
        if (match) begin
          mdl.sx[s] = 9'(clampi(2 * nx - int'(ox[s]), 0, FW - 1));
          mdl.sy[s] = 8'(clampi(2 * ny - int'(oy[s]), 0, FH - 1));
        end else begin
          mdl.sx[s] = 9'(nx); mdl.sy[s] = 8'(ny);
        end
`else
        mdl.sx[s] = 9'(nx); mdl.sy[s] = 8'(ny);
`endif
      end else begin
        mdl.v[s] = 1'b0; mdl.j[s] = 1'b0;
      end
    end
    m_init = 1; m_prevn = n;
    lat = match ? n + 1 : 1;
  endtask

  // Monitor: samples on the falling edge, compares results and drops, and checks stability between frames.
  always @(negedge clk) begin
    if (!rst) begin
      while (drop_q.size() > 0 && drop_q[0] < cyc) begin
        tests++; fails++;
        $display("FAIL dropped_out_missing cyc=%0d got=0 want=1 at %0d", cyc, drop_q[0]);
        void'(drop_q.pop_front());
      end
      if ((drop_q.size() > 0 && drop_q[0] == cyc) || bus.dropped_out) begin
        if (drop_q.size() > 0 && drop_q[0] == cyc) begin
          void'(drop_q.pop_front());
          chk("dropped_out", 256'(bus.dropped_out), 256'(1));
        end else chk("dropped_out_spurious", 256'(bus.dropped_out), 256'(0));
      end
      if (bus.data_valid_out) begin
        if (exp_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_data_valid_out cyc=%0d got=1 want=0", cyc);
        end else begin
          mon_e = exp_q.pop_front();
          chk("data_valid_out_latency", 256'(cyc), 256'(mon_e.cyc));
          chk("frame_outputs", dut_pack(), pack(mon_e));
          chk("busy_after_commit", 256'(bus.busy_out), 256'(0));
          held = mon_e;
          done_cnt++;
        end
      end else begin
        chk("outputs_stable", dut_pack(), pack(held));
      end
    end
  end

  task automatic drive_frame(input logic [6:0][8:0] cx, input logic [6:0][7:0] cy, input int n);
    int lat;
    exp_t e;
    @(posedge clk); #1;
    bus.centroids_x_in = cx; bus.centroids_y_in = cy;
    bus.num_balls = 3'(n); bus.data_valid_in = 1'b1;
    model_frame(cx, cy, n, lat);
    e = mdl; e.cyc = cyc + 1 + lat;
    exp_q.push_back(e);
    last_s = cyc + 1; last_lat = lat;
    @(posedge clk); #1;
    bus.data_valid_in = 1'b0;
  endtask

  // Issues a pulse sampled at edge d_edge. The caller guarantees the DUT is busy on that edge.
  task automatic drop_pulse(input int d_edge);
    while (cyc < d_edge - 1) begin @(posedge clk); #1; end
    bus.centroids_x_in = {7{9'($urandom_range(0, FW - 1))}};
    bus.centroids_y_in = {7{8'($urandom_range(0, FH - 1))}};
    bus.num_balls = 3'($urandom_range(0, 7));
    bus.data_valid_in = 1'b1;
    drop_q.push_back(d_edge);
    @(posedge clk); #1;
    bus.data_valid_in = 1'b0;
  endtask

  task automatic wait_done(input int target);
    int k;
    k = 0;
    while (done_cnt < target && k < 200) begin @(posedge clk); #1; k++; end
    if (done_cnt < target) begin
      tests++; fails++;
      $display("FAIL frame_timeout got=%0d want=%0d", done_cnt, target);
      exp_q.delete();
    end
  endtask

  task automatic frame(input logic [6:0][8:0] cx, input logic [6:0][7:0] cy, input int n);
    int base;
    base = done_cnt;
    drive_frame(cx, cy, n);
    wait_done(base + 1);
  endtask

  function automatic logic [6:0][8:0] px3(input int a, input int b, input int c);
    logic [6:0][8:0] r;
    r = '0; r[0] = 9'(a); r[1] = 9'(b); r[2] = 9'(c);
    return r;
  endfunction

  function automatic logic [6:0][7:0] py3(input int a, input int b, input int c);
    logic [6:0][7:0] r;
    r = '0; r[0] = 8'(a); r[1] = 8'(b); r[2] = 8'(c);
    return r;
  endfunction

  initial begin
    logic [6:0][8:0] cx, sx_exp;
    logic [6:0][7:0] cy;
    int base, n, src, tmp, jj;
    int perm[7];

    bus.centroids_x_in = '0; bus.centroids_y_in = '0;
    bus.num_balls = '0; bus.data_valid_in = 1'b0;
    reset_model(); held = mdl;
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 7; i++) sx_exp[i] = 9'((i + 1) * 40);
    chk("reset_seed_x", 256'(bus.seed_x_out), 256'(sx_exp));
    chk("reset_seed_y", 256'(bus.seed_y_out), 256'({7{8'd90}}));
    chk("reset_track_valid", 256'(bus.track_valid_out), 256'(0));
    chk("reset_busy", 256'(bus.busy_out), 256'(0));
    rst = 1'b0;

    // First frame: identity assignment.
    frame(px3(10, 100, 200), py3(10, 50, 100), 3);
    chk("first_valid", 256'(bus.track_valid_out), 256'(7'b0000111));
    // Permuted frame with a drop mid-match and a drop on the commit edge.
    base = done_cnt;
    drive_frame(px3(202, 12, 99), py3(98, 11, 52), 3);
    chk("busy_while_matching", 256'(bus.busy_out), 256'(1));
    drop_pulse(last_s + 2);
    drop_pulse(last_s + 4);
    wait_done(base + 1);
    // Slot 1 jumps by 61.
    frame(px3(12, 160, 202), py3(11, 52, 98), 3);
    chk("jump_slot1_x", 256'(bus.tracks_x_out[1]), 256'(160));
    chk("jump_vector", 256'(bus.jump_out), 256'(7'b0000010));
    // Candidates 1 and 2 are both 10 from track 0, so the lower index wins.
    frame(px3(160, 12, 22), py3(52, 21, 11), 3);
    chk("tie_slot0_y", 256'(bus.tracks_y_out[0]), 256'(21));

    // Reset asserted in the middle of a match.
    drive_frame(px3(15, 150, 30), py3(20, 50, 15), 3);
    @(posedge clk); #2;
    rst = 1'b1;
    exp_q.delete(); drop_q.delete();
    reset_model(); held = mdl;
    #1;
    chk("reset_mid_match", dut_pack(), pack(held));
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // A change in n forces identity; n = 0 clears valid bits and keeps seeds.
    cx = '0; cy = '0;
    for (int i = 0; i < 7; i++) begin cx[i] = 9'(30 * i + 5); cy[i] = 8'(20 * i + 3); end
    frame(cx, cy, 4);
    for (int i = 0; i < 7; i++) begin cx[i] = 9'(30 * (6 - i) + 9); cy[i] = 8'(20 * (6 - i) + 1); end
    frame(cx, cy, 4);
    frame(cx, cy, 2);
    frame(cx, cy, 0);
    chk("n0_valid_cleared", 256'(bus.track_valid_out), 256'(0));

    // Velocity prediction: track (300,170) after (280,160).
    frame(px3(280, 0, 0), py3(160, 0, 0), 1);
    frame(px3(300, 0, 0), py3(170, 0, 0), 1);
`ifdef VELOCITY_PREDICT_EN
    chk("seed_clamp_x", 256'(bus.seed_x_out[0]), 256'(319));
    chk("seed_clamp_y", 256'(bus.seed_y_out[0]), 256'(179));
`else
    chk("seed_follows_x", 256'(bus.seed_x_out[0]), 256'(300));
    chk("seed_follows_y", 256'(bus.seed_y_out[0]), 256'(170));
`endif

    // Random frames: mostly jittered permutations of the current tracks with the same n.
    for (int f = 0; f < 60; f++) begin
      n = ($urandom_range(0, 9) < 7) ? m_prevn : int'($urandom_range(0, 7));
      for (int i = 0; i < 7; i++) begin
        perm[i] = i;
        cx[i] = 9'($urandom_range(0, FW - 1));
        cy[i] = 8'($urandom_range(0, FH - 1));
      end
      for (int i = 6; i > 0; i--) begin
        jj = int'($urandom_range(0, i));
        tmp = perm[i]; perm[i] = perm[jj]; perm[jj] = tmp;
      end
      if (n == m_prevn) begin
        for (int i = 0; i < n; i++) begin
          src = perm[i];
          cx[i] = 9'(clampi(int'(mdl.tx[src]) + int'($urandom_range(0, 70)) - 35, 0, FW - 1));
          cy[i] = 8'(clampi(int'(mdl.ty[src]) + int'($urandom_range(0, 70)) - 35, 0, FH - 1));
        end
      end
      base = done_cnt;
      drive_frame(cx, cy, n);
      if ($urandom_range(0, 3) == 0) drop_pulse(last_s + int'($urandom_range(1, last_lat)));
      wait_done(base + 1);
    end

    repeat (3) @(posedge clk);
    #1;
    if (exp_q.size() != 0 || drop_q.size() != 0) begin
      tests++; fails++;
      $display("FAIL scoreboard_leftover got=%0d want=0", exp_q.size() + drop_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
